// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats and
// the register-usage table consulted by the load-use interlock.
package rv_decode_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_I) || (op == OP_R) || (op == OP_B) ||
           (op == OP_L) || (op == OP_S) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_B) || (op == OP_S);
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator; takes instruction bits [31:7]
// since the opcode field never contributes to an immediate.
module rv_imm_gen
  import rv_decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes RV32I from fetch, selects ALU operands and
// registers the bundle behind a valid/ready handshake with load-use interlock.
module alu_issue_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_func3,
  output logic [6:0]       ex_func7,
  output logic [XLEN-1:0]  ex_operand1,
  output logic [XLEN-1:0]  ex_operand2,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [XLEN-1:0]  ex_br_offset,
  output logic [4:0]       ex_rd,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] issue_count
);

  logic [6:0]      opcode;
  logic [2:0]      func3;
  imm_fmt_e        imm_fmt;
  logic [31:0]     imm;
  logic [6:0]      dec_func7;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic [XLEN-1:0] dec_store;
  logic [XLEN-1:0] dec_offset;
  logic [4:0]      dec_rd;
  logic            dec_illegal;
  logic            stall;
  logic            accept;

  assign opcode   = in_instr[6:0];
  assign func3    = in_instr[14:12];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  rv_imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  always_comb begin
    imm_fmt     = IMM_NONE;
    dec_func7   = 7'b0;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_store   = '0;
    dec_offset  = '0;
    dec_rd      = in_instr[11:7];
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        dec_func7 = in_instr[31:25];
        dec_op1   = rs1_data;
        dec_op2   = rs2_data;
      end
      // Only shifts carry a real func7; other I-type ops keep imm bits off it
      OP_I: begin
        imm_fmt = IMM_I;
        if (func3 == 3'b001 || func3 == 3'b101) dec_func7 = in_instr[31:25];
        dec_op1 = rs1_data;
        dec_op2 = imm;
      end
      OP_L, OP_JALR: begin
        imm_fmt = IMM_I;
        dec_op1 = rs1_data;
        dec_op2 = imm;
      end
      OP_S: begin
        imm_fmt   = IMM_S;
        dec_op1   = rs1_data;
        dec_op2   = imm;
        dec_store = rs2_data;
        dec_rd    = 5'd0;
      end
      OP_B: begin
        imm_fmt    = IMM_B;
        dec_op1    = rs1_data;
        dec_op2    = rs2_data;
        dec_offset = imm;
        dec_rd     = 5'd0;
      end
      OP_LUI: begin
        imm_fmt = IMM_U;
        dec_op2 = imm;
      end
      OP_AUIPC: begin
        imm_fmt = IMM_U;
        dec_op1 = in_pc;
        dec_op2 = imm;
      end
      OP_JAL: begin
        imm_fmt    = IMM_J;
        dec_op1    = in_pc;
        dec_offset = imm;
      end
      default: begin
        dec_rd      = 5'd0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // A load still sitting in execute cannot forward; hold a dependent consumer once
  always_comb begin
    stall = 1'b0;
    if (ex_valid && ex_opcode == OP_L && ex_rd != 5'd0) begin
      stall = (uses_rs1(opcode) && rs1_addr == ex_rd) ||
              (uses_rs2(opcode) && rs2_addr == ex_rd);
    end
  end

  assign in_ready = !stall && (!ex_valid || ex_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_opcode     <= '0;
      ex_func3      <= '0;
      ex_func7      <= '0;
      ex_operand1   <= '0;
      ex_operand2   <= '0;
      ex_store_data <= '0;
      ex_br_offset  <= '0;
      ex_rd         <= '0;
      ex_illegal    <= 1'b0;
      issue_count   <= '0;
    end else begin
      if (ex_valid && ex_ready) issue_count <= issue_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid      <= 1'b1;
        ex_opcode     <= opcode;
        ex_func3      <= func3;
        ex_func7      <= dec_func7;
        ex_operand1   <= dec_op1;
        ex_operand2   <= dec_op2;
        ex_store_data <= dec_store;
        ex_br_offset  <= dec_offset;
        ex_rd         <= dec_rd;
        ex_illegal    <= dec_illegal;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with hand-computed vectors.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [6:0]  ex_func7;
  logic [31:0] ex_operand1;
  logic [31:0] ex_operand2;
  logic [31:0] ex_store_data;
  logic [31:0] ex_br_offset;
  logic [4:0]  ex_rd;
  logic        ex_illegal;
  logic [31:0] issue_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_opcode     (ex_opcode),
    .ex_func3      (ex_func3),
    .ex_func7      (ex_func7),
    .ex_operand1   (ex_operand1),
    .ex_operand2   (ex_operand2),
    .ex_store_data (ex_store_data),
    .ex_br_offset  (ex_br_offset),
    .ex_rd         (ex_rd),
    .ex_illegal    (ex_illegal),
    .issue_count   (issue_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic er, input logic fl);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    rs1_data = d1;
    rs2_data = d2;
    ex_ready = er;
    flush    = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rst_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("rst_count", issue_count, 32'd0);
    checkOutput("rst_opcode", {25'b0, ex_opcode}, 32'd0);
    checkOutput("rst_op2", ex_operand2, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    applyStimulus(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("addi_rs1_addr", {27'b0, rs1_addr}, 32'd0);
    checkOutput("addi_rs2_addr", {27'b0, rs2_addr}, 32'd5);
    step();
    checkOutput("addi_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("addi_opcode", {25'b0, ex_opcode}, 32'h13);
    checkOutput("addi_func3", {29'b0, ex_func3}, 32'd0);
    checkOutput("addi_func7", {25'b0, ex_func7}, 32'd0);
    checkOutput("addi_op2", ex_operand2, 32'd5);
    checkOutput("addi_rd", {27'b0, ex_rd}, 32'd1);

    // SRAI x2,x1,3
    applyStimulus(1'b1, 32'h4030D113, 32'h1, 32'h80000000, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("srai_func7", {25'b0, ex_func7}, 32'h20);
    checkOutput("srai_shamt", {27'b0, ex_operand2[4:0]}, 32'd3);
    checkOutput("srai_op1", ex_operand1, 32'h80000000);
    checkOutput("srai_func3", {29'b0, ex_func3}, 32'd5);
    checkOutput("srai_count", issue_count, 32'd1);

    // ANDI x2,x1,-1
    applyStimulus(1'b1, 32'hFFF0F113, 32'h2, 32'h0000000F, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("andi_func7", {25'b0, ex_func7}, 32'd0);
    checkOutput("andi_op2", ex_operand2, 32'hFFFFFFFF);
    checkOutput("andi_func3", {29'b0, ex_func3}, 32'd7);

    // LUI x3,0x12345 with junk on rs1_data
    applyStimulus(1'b1, 32'h123451B7, 32'h3, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("lui_op2", ex_operand2, 32'h12345000);
    checkOutput("lui_op1", ex_operand1, 32'd0);
    checkOutput("lui_rd", {27'b0, ex_rd}, 32'd3);

    // JAL x1,+8 at pc 0x10
    applyStimulus(1'b1, 32'h008000EF, 32'h10, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0);
    step();
    checkOutput("jal_op1", ex_operand1, 32'h10);
    checkOutput("jal_op2", ex_operand2, 32'd0);
    checkOutput("jal_rd", {27'b0, ex_rd}, 32'd1);
    checkOutput("jal_offset", ex_br_offset, 32'd8);
    checkOutput("jal_count", issue_count, 32'd4);

    // Back-pressure for three cycles with SUB x7,x2,x3 waiting
    applyStimulus(1'b1, 32'h403103B3, 32'h11, 32'h00000064, 32'h00000007, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      checkOutput("hold_valid", {31'b0, ex_valid}, 32'd1);
      checkOutput("hold_opcode", {25'b0, ex_opcode}, 32'h6F);
      checkOutput("hold_op1", ex_operand1, 32'h10);
      checkOutput("hold_count", issue_count, 32'd4);
    end
    applyStimulus(1'b1, 32'h403103B3, 32'h11, 32'h00000064, 32'h00000007, 1'b1, 1'b0);
    checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    checkOutput("sub_opcode", {25'b0, ex_opcode}, 32'h33);
    checkOutput("sub_func7", {25'b0, ex_func7}, 32'h20);
    checkOutput("sub_op1", ex_operand1, 32'h64);
    checkOutput("sub_op2", ex_operand2, 32'h7);
    checkOutput("sub_rd", {27'b0, ex_rd}, 32'd7);
    checkOutput("sub_count", issue_count, 32'd5);

    // LW x5,0(x1) then dependent ADD x6,x5,x1: one bubble
    applyStimulus(1'b1, 32'h0000A283, 32'h12, 32'h100, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("lw_opcode", {25'b0, ex_opcode}, 32'h03);
    checkOutput("lw_rd", {27'b0, ex_rd}, 32'd5);
    applyStimulus(1'b1, 32'h00128333, 32'h13, 32'h1, 32'h2, 1'b1, 1'b0);
    checkOutput("loaduse_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    checkOutput("bubble_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("bubble_count", issue_count, 32'd7);
    checkOutput("after_bubble_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    checkOutput("add_dep_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("add_dep_rd", {27'b0, ex_rd}, 32'd6);
    checkOutput("add_dep_op1", ex_operand1, 32'h1);

    // LW x5 then independent ADD x6,x0,x1: no bubble
    applyStimulus(1'b1, 32'h0000A283, 32'h14, 32'h100, 32'h0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 32'h00100333, 32'h15, 32'h0, 32'h9, 1'b1, 1'b0);
    checkOutput("nodep_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    checkOutput("nodep_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("nodep_opcode", {25'b0, ex_opcode}, 32'h33);
    checkOutput("nodep_count", issue_count, 32'd9);

    // Flush while a bundle is held and fetch offers ADDI
    applyStimulus(1'b1, 32'h00500093, 32'h16, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    checkOutput("flush_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("flush_count", issue_count, 32'd9);
    applyStimulus(1'b1, 32'h00500093, 32'h16, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("postflush_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("postflush_op2", ex_operand2, 32'd5);

    // SW x2,8(x1)
    applyStimulus(1'b1, 32'h0020A423, 32'h17, 32'h200, 32'h55AA55AA, 1'b1, 1'b0);
    step();
    checkOutput("sw_op1", ex_operand1, 32'h200);
    checkOutput("sw_op2", ex_operand2, 32'd8);
    checkOutput("sw_store", ex_store_data, 32'h55AA55AA);
    checkOutput("sw_rd", {27'b0, ex_rd}, 32'd0);

    // Illegal opcode 1111111
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h18, 32'h12345678, 32'h87654321, 1'b1, 1'b0);
    step();
    checkOutput("ill_flag", {31'b0, ex_illegal}, 32'd1);
    checkOutput("ill_opcode", {25'b0, ex_opcode}, 32'h7F);
    checkOutput("ill_func3", {29'b0, ex_func3}, 32'd7);
    checkOutput("ill_op1", ex_operand1, 32'd0);
    checkOutput("ill_op2", ex_operand2, 32'd0);
    checkOutput("ill_rd", {27'b0, ex_rd}, 32'd0);
    checkOutput("ill_count", issue_count, 32'd11);

    // Reset asserted during a load-use stall with execute back-pressured
    applyStimulus(1'b1, 32'h0000A283, 32'h19, 32'h100, 32'h0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 32'h00128333, 32'h1A, 32'h1, 32'h2, 1'b0, 1'b0);
    checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    checkOutput("midrst_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("midrst_count", issue_count, 32'd0);
    checkOutput("midrst_opcode", {25'b0, ex_opcode}, 32'd0);
    checkOutput("midrst_op1", ex_operand1, 32'd0);
    checkOutput("midrst_rd", {27'b0, ex_rd}, 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
